stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Multi-register PUSH/POP engine for the Thumb core. It is the initiator side of the register file port. It reads SP, walks a register list, moves each register to or from data memory over a req/ack handshake, writes back the final SP, and pulses `done`. It sits between the decode/execute stage and the register file plus memory port.

## Interface
Parameters:
- none (word size is fixed at 4 bytes; selector codes live in the package)

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `is_pop` in 1: 0 = PUSH, 1 = POP.
- `reg_list` in 8: bit i selects r i.
- `extra_en` in 1: adds LR for PUSH, or PC for POP.
- `busy` out 1: high from the cycle after `start` through the DONE cycle.
- `done` out 1: one-cycle completion pulse.
- `rd0_select` out 4: register file read port 0 select (data registers).
- `rd1_select` out 4: register file read port 1 select; 4'hd while reading SP.
- `data_out0` in 32: registered read data for port 0, valid one posedge after select.
- `data_out1` in 32: registered read data for port 1, valid one posedge after select.
- `write_en` out 1: register file write strobe.
- `wr_select` out 4: register file write index.
- `data_in` out 32: register file write data.
- `sp_write_en` out 1: SP write strobe.
- `sp_in` out 32: new SP value.
- `mem_req` out 1: memory request; held until ack.
- `mem_we` out 1: 1 = store, 0 = load.
- `mem_addr` out 32: byte address.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: load data, valid with `mem_ack`.
- `mem_ack` in 1: access complete; earliest in the first cycle `mem_req` is high.
- `pc_load` out 1: one-cycle pulse when POP loads PC.
- `pc_value` out 32: loaded PC value, valid with `pc_load`.

## Operation
- Reset value of every output is 0. `rst` in any state returns to IDLE the next posedge. An outstanding `mem_req` is dropped, and no further register file or SP writes occur.
- Count N = popcount(`reg_list`) + `extra_en`.
- N = 0: IDLE -> DONE directly. No memory access, no SP write.
- States:
  - IDLE.
  - SP_RD: `rd1_select`=4'hd.
  - SP_CAP: capture `data_out1`. PUSH sets base = SP - 4N; POP sets base = SP. Both set addr = base.
  - RD (PUSH only): `rd0_select` = lowest remaining index, or 4'he for LR.
  - MEM: hold req/we/addr/wdata stable until `mem_ack`.
  - WB (POP only): write r i. For the PC slot, pulse `pc_load` instead of writing the register file.
  - SP_WB: `sp_write_en`=1. PUSH writes `sp_in` = SP - 4N; POP writes SP + 4N.
  - DONE: `done`=1, then IDLE.
- Ordering:
  - Lowest register goes to the lowest address, then ascending; LR/PC is always last (highest address).
  - After each MEM (PUSH) or WB (POP): clear the serviced bit and add 4 to addr. Return to RD/MEM while bits remain, else go to SP_WB.
- Arithmetic is modulo 2^32 with no alignment check; wrap-around past 0 or 0xFFFFFFFF is passed through unchanged.
- `start` while busy is ignored; inputs are latched in IDLE only.
- The register file commits writes at the negedge of the WB/SP_WB cycle, so a read selected in the following cycle sees the new value.

## Timing
- Cycle 0 = `start` sampled in IDLE. Cycles 1-2 are SP_RD and SP_CAP.
- Zero-wait memory (ack in the first MEM cycle):
  - each register takes 2 cycles (PUSH: RD+MEM; POP: MEM+WB);
  - SP_WB at cycle 3+2N, `done` at cycle 4+2N.
- Each wait cycle on `mem_ack` adds exactly one cycle.
- N = 0: `done` at cycle 1.
- `busy`=1 from cycle 1 to the `done` cycle inclusive.
- `mem_wdata` is taken from `data_out0` captured in the RD->MEM transition.
- `data_in` in WB is `mem_rdata` registered on ack.

## Structure
- Package `stack_seq_pkg` holds:
  - state enum `stack_state_t`;
  - constants `SEL_SP`=4'hd, `SEL_LR`=4'he, `WORD_BYTES`=4;
  - width constants for the 9-bit work mask.
- Sub-module `lowest_set_bit`: a combinational 9-bit priority encoder returning index plus valid. It is shared by the next-register select and the loop-exit test.

## Test plan
- PUSH `reg_list`=0x03, `extra_en`=0, SP=0x1000, r0=0x11, r1=0x22, zero-wait memory -> stores 0x0FF8<-0x11 then 0x0FFC<-0x22; `sp_in`=0x0FF8; `done` at cycle 8.
- PUSH `reg_list`=0x10, `extra_en`=1, SP=0x2000, r4=0x44, LR=0xeeeeffff -> 0x1FF8<-0x44, 0x1FFC<-0xeeeeffff; SP becomes 0x1FF8.
- POP `reg_list`=0x04, `extra_en`=1, SP=0x1FF8, mem[0x1FF8]=0xAAAA, mem[0x1FFC]=0x0100 -> r2 written 0xAAAA; `pc_load` pulse with `pc_value`=0x0100; SP becomes 0x2000; r15 never written to the register file.
- PUSH of 2 registers with `mem_ack` delayed 3 cycles each -> req, addr and wdata stable while waiting; `done` at cycle 14.
- `reg_list`=0, `extra_en`=0 -> `done` at cycle 1; no `mem_req`, no `sp_write_en`, no `write_en`.
- `rst` asserted during POP of 3 registers, after the first WB -> all outputs 0 and `busy`=0 the next cycle; SP not written; a new `start` two cycles later runs normally.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg -- shared types and constants for the PUSH/POP stack sequencer.
// Revision 1.0
`default_nettype none

package stack_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SP_RD  = 3'd1,
    S_SP_CAP = 3'd2,
    S_RD     = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_SP_WB  = 3'd6,
    S_DONE   = 3'd7
  } stack_state_t;

  localparam logic [3:0]  SEL_SP     = 4'hd;
  localparam logic [3:0]  SEL_LR     = 4'he;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Work mask: bits 0..7 are r0..r7, bit 8 is the LR/PC slot.
  localparam int          MASK_W     = 9;
  localparam int          IDX_W      = 4;
  localparam logic [3:0]  EXTRA_IDX  = 4'd8;
  localparam logic [3:0]  IDX_NONE   = 4'hf;

  function automatic logic [IDX_W-1:0] popcount9(input logic [MASK_W-1:0] m);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int i = 0; i < MASK_W; i++) begin
      c = c + {{(IDX_W-1){1'b0}}, m[i]};
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_sequencer_lowest_set_bit.sv
// lowest_set_bit -- combinational priority encoder over the 9-bit work mask.
// Revision 1.0
`default_nettype none

module lowest_set_bit
  import stack_seq_pkg::*;
(
  input  logic [MASK_W-1:0] mask,
  output logic [IDX_W-1:0]  index,
  output logic              valid
);

  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stack_sequencer.sv
// stack_sequencer -- multi-register PUSH/POP engine driving the register file and memory port.
// Revision 1.0
`default_nettype none

module stack_sequencer
  import stack_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_pop,
  input  logic [7:0]  reg_list,
  input  logic        extra_en,
  output logic        busy,
  output logic        done,
  output logic [3:0]  rd0_select,
  output logic [3:0]  rd1_select,
  input  logic [31:0] data_out0,
  input  logic [31:0] data_out1,
  output logic        write_en,
  output logic [3:0]  wr_select,
  output logic [31:0] data_in,
  output logic        sp_write_en,
  output logic [31:0] sp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pc_load,
  output logic [31:0] pc_value
);

  stack_state_t     r_state, w_next;
  logic             r_pop;
  logic [MASK_W-1:0] r_mask;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_count;
  logic [31:0]      r_sp, r_addr, r_rdata;

  logic [MASK_W-1:0] w_cur_bit, w_rest;
  logic [IDX_W-1:0] w_next_idx, w_n_in;
  logic             w_more, w_is_extra;
  logic [31:0]      w_bytes;

  // r_idx = IDX_NONE before the first slot, so w_rest is then the whole mask.
  assign w_cur_bit  = {{(MASK_W-1){1'b0}}, 1'b1} << r_idx;
  assign w_rest     = r_mask & ~w_cur_bit;
  assign w_is_extra = (r_idx == EXTRA_IDX);
  assign w_bytes    = 32'(r_count) * WORD_BYTES;
  assign w_n_in     = popcount9({extra_en, reg_list});

  lowest_set_bit u_lsb (
    .mask  (w_rest),
    .index (w_next_idx),
    .valid (w_more)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pop   <= 1'b0;
      r_mask  <= '0;
      r_idx   <= IDX_NONE;
      r_count <= '0;
      r_sp    <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_pop   <= is_pop;
          r_mask  <= {extra_en, reg_list};
          r_count <= w_n_in;
          r_idx   <= IDX_NONE;
        end
        S_SP_CAP: begin
          r_sp   <= data_out1;
          r_addr <= r_pop ? data_out1 : data_out1 - w_bytes;
          r_idx  <= w_next_idx;
        end
        S_MEM: if (mem_ack) begin
          if (r_pop) begin
            r_rdata <= mem_rdata;
          end else begin
            r_mask <= w_rest;
            r_idx  <= w_next_idx;
            r_addr <= r_addr + WORD_BYTES;
          end
        end
        S_WB: begin
          r_mask <= w_rest;
          r_idx  <= w_next_idx;
          r_addr <= r_addr + WORD_BYTES;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    rd0_select  = '0;
    rd1_select  = '0;
    write_en    = 1'b0;
    wr_select   = '0;
    data_in     = '0;
    sp_write_en = 1'b0;
    sp_in       = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    pc_load     = 1'b0;
    pc_value    = '0;
    case (r_state)
      S_IDLE:   if (start) w_next = (w_n_in == '0) ? S_DONE : S_SP_RD;
      S_SP_RD: begin
        rd1_select = SEL_SP;
        w_next     = S_SP_CAP;
      end
      S_SP_CAP: w_next = r_pop ? S_MEM : S_RD;
      S_RD: begin
        rd0_select = w_is_extra ? SEL_LR : r_idx;
        w_next     = S_MEM;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = ~r_pop;
        mem_addr = r_addr;
        // Select held through MEM so the registered read data stays stable.
        if (!r_pop) begin
          rd0_select = w_is_extra ? SEL_LR : r_idx;
          mem_wdata  = data_out0;
        end
        if (mem_ack) begin
          if (r_pop)       w_next = S_WB;
          else if (w_more) w_next = S_RD;
          else             w_next = S_SP_WB;
        end
      end
      S_WB: begin
        if (w_is_extra) begin
          pc_load  = 1'b1;
          pc_value = r_rdata;
        end else begin
          write_en  = 1'b1;
          wr_select = r_idx;
          data_in   = r_rdata;
        end
        w_next = w_more ? S_MEM : S_SP_WB;
      end
      S_SP_WB: begin
        sp_write_en = 1'b1;
        sp_in       = r_pop ? r_sp + w_bytes : r_sp - w_bytes;
        w_next      = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer -- directed bench with register file and memory models.
// Revision 1.0
`default_nettype none

module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_pop = 1'b0, extra_en = 1'b0;
  logic [7:0]  reg_list = 8'h00;
  logic [31:0] data_out0 = '0, data_out1 = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, write_en, sp_write_en, mem_req, mem_we, pc_load;
  logic [3:0]  rd0_select, rd1_select, wr_select;
  logic [31:0] data_in, sp_in, mem_addr, mem_wdata, pc_value;

  stack_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_pop(is_pop), .reg_list(reg_list),
    .extra_en(extra_en), .busy(busy), .done(done), .rd0_select(rd0_select),
    .rd1_select(rd1_select), .data_out0(data_out0), .data_out1(data_out1),
    .write_en(write_en), .wr_select(wr_select), .data_in(data_in),
    .sp_write_en(sp_write_en), .sp_in(sp_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pc_load(pc_load), .pc_value(pc_value)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [16];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] st_a [$];
  logic [31:0] st_d [$];
  int          ack_delay = 0, wcnt = 0, unstable = 0;
  int          n_wr = 0, n_spw = 0, n_pcl = 0, n_req = 0;
  logic [31:0] last_pc = '0, h_addr = '0, h_wdata = '0;
  logic        h_we = 1'b0;
  int          pass_cnt = 0, total = 0;

  // Register file: registered reads, writes committed at negedge.
  always @(posedge clk) begin
    data_out0 <= regs[rd0_select];
    data_out1 <= regs[rd1_select];
  end

  always @(negedge clk) begin
    if (write_en) begin regs[wr_select] = data_in; n_wr++; end
    if (sp_write_en) begin regs[4'hd] = sp_in; n_spw++; end
    if (pc_load) begin n_pcl++; last_pc = pc_value; end
    if (mem_req) n_req++;
  end

  // Memory responder with programmable wait cycles and stability tracking.
  always @(negedge clk) begin
    if (!mem_req || rst) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else begin
      if (wcnt == 0) begin
        h_addr = mem_addr; h_wdata = mem_wdata; h_we = mem_we;
      end else if (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_we !== h_we) begin
        unstable++;
      end
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          st_a.push_back(mem_addr);
          st_d.push_back(mem_wdata);
        end else begin
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic clear_logs();
    n_wr = 0; n_spw = 0; n_pcl = 0; n_req = 0; unstable = 0;
    st_a.delete(); st_d.delete();
  endtask

  // Launches one operation; dc is the cycle done was seen (-1 on timeout), b1 is busy at cycle 1.
  task automatic run(input logic pop, input logic [7:0] list, input logic ext,
                     output int dc, output logic b1);
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; is_pop = pop; reg_list = list; extra_en = ext;
    @(posedge clk); #1;
    start = 1'b0; is_pop = 1'b0; reg_list = 8'h00; extra_en = 1'b0;
    dc = 1;
    b1 = busy;
    while (!done && dc < 200) begin
      @(posedge clk); #1;
      dc++;
    end
    if (!done) dc = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, done, mem_req, mem_we, write_en, sp_write_en, pc_load} !== 7'b0)
      $display("FAIL reset_strobes: got %b expected 0000000", {busy, done, mem_req, mem_we, write_en, sp_write_en, pc_load}); else pass_cnt++;
    total++; if ({rd0_select, rd1_select, wr_select} !== 12'h000)
      $display("FAIL reset_selects: got %h expected 000", {rd0_select, rd1_select, wr_select}); else pass_cnt++;
    total++; if ((data_in | sp_in | mem_addr | mem_wdata | pc_value) !== 32'h0)
      $display("FAIL reset_buses: got %h expected 00000000", data_in | sp_in | mem_addr | mem_wdata | pc_value); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_push_basic();
    int dc; logic b1;
    regs[13] = 32'h1000; regs[0] = 32'h11; regs[1] = 32'h22;
    run(1'b0, 8'h03, 1'b0, dc, b1);
    total++; if (dc !== 8) $display("FAIL push_done_cycle: got %0d expected 8", dc); else pass_cnt++;
    total++; if (b1 !== 1'b1) $display("FAIL push_busy_c1: got %b expected 1", b1); else pass_cnt++;
    total++; if (st_a.size() !== 2) $display("FAIL push_store_count: got %0d expected 2", st_a.size());
    else begin
      pass_cnt++;
      total++; if (st_a[0] !== 32'h0FF8 || st_d[0] !== 32'h11)
        $display("FAIL push_store0: got %h<-%h expected 00000ff8<-00000011", st_a[0], st_d[0]); else pass_cnt++;
      total++; if (st_a[1] !== 32'h0FFC || st_d[1] !== 32'h22)
        $display("FAIL push_store1: got %h<-%h expected 00000ffc<-00000022", st_a[1], st_d[1]); else pass_cnt++;
    end
    total++; if (regs[13] !== 32'h0FF8) $display("FAIL push_sp: got %h expected 00000ff8", regs[13]); else pass_cnt++;
    total++; if (n_wr !== 0 || n_spw !== 1) $display("FAIL push_writes: got wr=%0d spw=%0d expected wr=0 spw=1", n_wr, n_spw); else pass_cnt++;
  endtask

  task automatic test_push_lr();
    int dc; logic b1;
    regs[13] = 32'h2000; regs[4] = 32'h44; regs[14] = 32'heeeeffff;
    run(1'b0, 8'h10, 1'b1, dc, b1);
    total++; if (dc !== 8) $display("FAIL pushlr_done_cycle: got %0d expected 8", dc); else pass_cnt++;
    total++; if (st_a.size() !== 2) $display("FAIL pushlr_store_count: got %0d expected 2", st_a.size());
    else begin
      pass_cnt++;
      total++; if (st_a[0] !== 32'h1FF8 || st_d[0] !== 32'h44)
        $display("FAIL pushlr_store0: got %h<-%h expected 00001ff8<-00000044", st_a[0], st_d[0]); else pass_cnt++;
      total++; if (st_a[1] !== 32'h1FFC || st_d[1] !== 32'heeeeffff)
        $display("FAIL pushlr_store_lr: got %h<-%h expected 00001ffc<-eeeeffff", st_a[1], st_d[1]); else pass_cnt++;
    end
    total++; if (regs[13] !== 32'h1FF8) $display("FAIL pushlr_sp: got %h expected 00001ff8", regs[13]); else pass_cnt++;
  endtask

  task automatic test_pop_pc();
    int dc; logic b1;
    regs[13] = 32'h1FF8; regs[2] = 32'h0; regs[15] = 32'hDEAD0000;
    mem[32'h1FF8] = 32'hAAAA; mem[32'h1FFC] = 32'h0100;
    run(1'b1, 8'h04, 1'b1, dc, b1);
    total++; if (dc !== 8) $display("FAIL pop_done_cycle: got %0d expected 8", dc); else pass_cnt++;
    total++; if (regs[2] !== 32'hAAAA) $display("FAIL pop_r2: got %h expected 0000aaaa", regs[2]); else pass_cnt++;
    total++; if (n_pcl !== 1 || last_pc !== 32'h0100)
      $display("FAIL pop_pc_load: got n=%0d pc=%h expected n=1 pc=00000100", n_pcl, last_pc); else pass_cnt++;
    total++; if (regs[13] !== 32'h2000) $display("FAIL pop_sp: got %h expected 00002000", regs[13]); else pass_cnt++;
    total++; if (regs[15] !== 32'hDEAD0000 || n_wr !== 1)
      $display("FAIL pop_no_pc_rf_write: got r15=%h wr=%0d expected r15=dead0000 wr=1", regs[15], n_wr); else pass_cnt++;
  endtask

  task automatic test_wait_states();
    int dc; logic b1;
    regs[13] = 32'h3000; regs[5] = 32'h55555555; regs[7] = 32'h77777777;
    ack_delay = 3;
    run(1'b0, 8'hA0, 1'b0, dc, b1);
    ack_delay = 0;
    total++; if (dc !== 14) $display("FAIL wait_done_cycle: got %0d expected 14", dc); else pass_cnt++;
    total++; if (unstable !== 0) $display("FAIL wait_stable: got %0d changes expected 0", unstable); else pass_cnt++;
    total++; if (n_req !== 8) $display("FAIL wait_req_cycles: got %0d expected 8", n_req); else pass_cnt++;
    total++; if (st_a.size() !== 2) $display("FAIL wait_store_count: got %0d expected 2", st_a.size());
    else begin
      pass_cnt++;
      total++; if (st_a[0] !== 32'h2FF8 || st_d[0] !== 32'h55555555)
        $display("FAIL wait_store0: got %h<-%h expected 00002ff8<-55555555", st_a[0], st_d[0]); else pass_cnt++;
      total++; if (st_a[1] !== 32'h2FFC || st_d[1] !== 32'h77777777)
        $display("FAIL wait_store1: got %h<-%h expected 00002ffc<-77777777", st_a[1], st_d[1]); else pass_cnt++;
    end
    total++; if (regs[13] !== 32'h2FF8) $display("FAIL wait_sp: got %h expected 00002ff8", regs[13]); else pass_cnt++;
  endtask

  task automatic test_empty();
    int dc; logic b1;
    run(1'b0, 8'h00, 1'b0, dc, b1);
    total++; if (dc !== 1) $display("FAIL empty_done_cycle: got %0d expected 1", dc); else pass_cnt++;
    total++; if (n_req !== 0 || n_spw !== 0 || n_wr !== 0)
      $display("FAIL empty_no_access: got req=%0d spw=%0d wr=%0d expected 0 0 0", n_req, n_spw, n_wr); else pass_cnt++;
  endtask

  task automatic test_reset_mid_pop();
    int dc; logic b1;
    regs[13] = 32'h4000; regs[0] = 32'h0; regs[1] = 32'h0; regs[2] = 32'h0;
    mem[32'h4000] = 32'h1; mem[32'h4004] = 32'h2; mem[32'h4008] = 32'h3;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; is_pop = 1'b1; reg_list = 8'h07;
    @(posedge clk); #1;
    start = 1'b0; is_pop = 1'b0; reg_list = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    total++; if (regs[0] !== 32'h1 || mem_req !== 1'b1)
      $display("FAIL rstmid_first_wb: got r0=%h req=%b expected r0=00000001 req=1", regs[0], mem_req); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({busy, done, mem_req, write_en, sp_write_en, pc_load} !== 6'b0 || mem_addr !== 32'h0)
      $display("FAIL rstmid_outputs: got %b addr=%h expected 000000 addr=00000000",
               {busy, done, mem_req, write_en, sp_write_en, pc_load}, mem_addr); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (regs[1] !== 32'h0 || n_spw !== 0 || regs[13] !== 32'h4000)
      $display("FAIL rstmid_no_writes: got r1=%h spw=%0d sp=%h expected r1=0 spw=0 sp=00004000", regs[1], n_spw, regs[13]); else pass_cnt++;
    run(1'b1, 8'h07, 1'b0, dc, b1);
    total++; if (dc !== 10) $display("FAIL rstmid_rerun_cycle: got %0d expected 10", dc); else pass_cnt++;
    total++; if (regs[0] !== 32'h1 || regs[1] !== 32'h2 || regs[2] !== 32'h3)
      $display("FAIL rstmid_rerun_regs: got %h %h %h expected 1 2 3", regs[0], regs[1], regs[2]); else pass_cnt++;
    total++; if (regs[13] !== 32'h400C) $display("FAIL rstmid_rerun_sp: got %h expected 0000400c", regs[13]); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    test_reset();
    test_push_basic();
    test_push_lr();
    test_pop_pc();
    test_wait_states();
    test_empty();
    test_reset_mid_pop();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
